tcb_gpio_irq: RTL and testbench

- Next-generation GPIO controller on the TCB system bus. It adds the following over the basic GPIO:
  - per-pin output set/clear/toggle registers;
  - byte-enabled writes;
  - address error reporting;
  - per-pin rising/falling edge detection with sticky interrupt status and a single level interrupt output to the core interrupt controller.
- Sits in the SoC peripheral region next to the UART and timer.

---
 rtl/tcb_gpio_irq.sv | 167 ++++++++++++++++
 tb/tb_tcb_gpio_irq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_gpio_irq.sv
// TCB GPIO controller with set/clear/toggle outputs and edge interrupts.
// Registered read response, sticky W1C status, level irq output.
module tcb_gpio_irq #(
    parameter int unsigned    GW          = 32,
    parameter int unsigned    CFG_CDC     = 2,
    parameter logic [GW-1:0]  CFG_RST_OUT = '0
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_vld,
    input  logic          bus_wen,
    input  logic [5:0]    bus_adr,
    input  logic [3:0]    bus_ben,
    input  logic [31:0]   bus_wdt,
    output logic [31:0]   bus_rdt,
    output logic          bus_rdy,
    output logic          bus_err,
    output logic [GW-1:0] gpio_o,
    output logic [GW-1:0] gpio_e,
    input  logic [GW-1:0] gpio_i,
    output logic          irq
);

    localparam logic [3:0] IDX_OUT  = 4'd0;
    localparam logic [3:0] IDX_OE   = 4'd1;
    localparam logic [3:0] IDX_IN   = 4'd2;
    localparam logic [3:0] IDX_SET  = 4'd3;
    localparam logic [3:0] IDX_CLR  = 4'd4;
    localparam logic [3:0] IDX_TGL  = 4'd5;
    localparam logic [3:0] IDX_RISE = 4'd6;
    localparam logic [3:0] IDX_FALL = 4'd7;
    localparam logic [3:0] IDX_STS  = 4'd8;

    logic [3:0]    idx;
    logic          adr_bad;
    logic          err_c;
    logic          wr;
    logic          rd;
    logic [31:0]   bmask;
    logic [GW-1:0] wmsk;
    logic [GW-1:0] wdat;
    logic [GW-1:0] w1c;
    logic [31:0]   rd_val;

    logic [GW-1:0] gpio_s;
    logic [GW-1:0] gpio_d;
    logic [GW-1:0] rise;
    logic [GW-1:0] fall;
    logic [GW-1:0] irq_rise;
    logic [GW-1:0] irq_fall;
    logic [GW-1:0] irq_sts;

    assign bus_rdy = 1'b1;

    assign idx     = bus_adr[5:2];
    assign adr_bad = (bus_adr[1:0] != 2'b00) || (idx > IDX_STS);
    assign err_c   = adr_bad || (bus_wen && (idx == IDX_IN));
    assign wr      = bus_vld && bus_wen && !err_c;
    assign rd      = bus_vld && !bus_wen && !err_c;

    assign bmask = {{8{bus_ben[3]}}, {8{bus_ben[2]}},
                    {8{bus_ben[1]}}, {8{bus_ben[0]}}};
    assign wmsk  = bmask[GW-1:0];
    assign wdat  = bus_wdt[GW-1:0] & wmsk;
    assign w1c   = (wr && (idx == IDX_STS)) ? wdat : '0;

    // Input synchronizer chain, or a straight wire when disabled.
    generate
        if (CFG_CDC == 0) begin : g_bypass
            assign gpio_s = gpio_i;
        end else begin : g_sync
            logic [GW-1:0] sync_q [CFG_CDC];

            // Shift the raw pins through the synchronizer stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(CFG_CDC); i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= gpio_i;
                    for (int i = 1; i < int'(CFG_CDC); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign gpio_s = sync_q[CFG_CDC-1];
        end
    endgenerate

    // Delayed copy of the synchronized inputs for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_d <= '0;
        end else begin
            gpio_d <= gpio_s;
        end
    end

    assign rise = gpio_s & ~gpio_d;
    assign fall = ~gpio_s & gpio_d;

    // Output, enable and interrupt-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_o   <= CFG_RST_OUT;
            gpio_e   <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
        end else if (wr) begin
            case (idx)
                IDX_OUT:  gpio_o   <= (gpio_o & ~wmsk) | wdat;
                IDX_OE:   gpio_e   <= (gpio_e & ~wmsk) | wdat;
                IDX_SET:  gpio_o   <= gpio_o | wdat;
                IDX_CLR:  gpio_o   <= gpio_o & ~wdat;
                IDX_TGL:  gpio_o   <= gpio_o ^ wdat;
                IDX_RISE: irq_rise <= (irq_rise & ~wmsk) | wdat;
                IDX_FALL: irq_fall <= (irq_fall & ~wmsk) | wdat;
                default:  ;
            endcase
        end
    end

    // Sticky status: fresh edges override a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sts <= '0;
        end else begin
            irq_sts <= (irq_sts & ~w1c)
                     | (rise & irq_rise)
                     | (fall & irq_fall);
        end
    end

    assign irq = |irq_sts;

    // Read data selection; write-only and unused slots read zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_OUT:  rd_val[GW-1:0] = gpio_o;
            IDX_OE:   rd_val[GW-1:0] = gpio_e;
            IDX_IN:   rd_val[GW-1:0] = gpio_s;
            IDX_RISE: rd_val[GW-1:0] = irq_rise;
            IDX_FALL: rd_val[GW-1:0] = irq_fall;
            IDX_STS:  rd_val[GW-1:0] = irq_sts;
            default:  rd_val = '0;
        endcase
    end

    // Registered response; read data holds across writes and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdt <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= bus_vld && err_c;
            if (bus_vld && err_c) begin
                bus_rdt <= '0;
            end else if (rd) begin
                bus_rdt <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_tcb_gpio_irq.sv
// Directed bench for tcb_gpio_irq.
// GW=32, CFG_CDC=2, reset OUT value 0.
module tb_tcb_gpio_irq;

    logic        clk;
    logic        rst_n;
    logic        bus_vld;
    logic        bus_wen;
    logic [5:0]  bus_adr;
    logic [3:0]  bus_ben;
    logic [31:0] bus_wdt;
    logic [31:0] bus_rdt;
    logic        bus_rdy;
    logic        bus_err;
    logic [31:0] gpio_o;
    logic [31:0] gpio_e;
    logic [31:0] gpio_i;
    logic        irq;

    int tests;
    int fails;

    tcb_gpio_irq #(
        .GW(32),
        .CFG_CDC(2),
        .CFG_RST_OUT(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_vld(bus_vld),
        .bus_wen(bus_wen),
        .bus_adr(bus_adr),
        .bus_ben(bus_ben),
        .bus_wdt(bus_wdt),
        .bus_rdt(bus_rdt),
        .bus_rdy(bus_rdy),
        .bus_err(bus_err),
        .gpio_o(gpio_o),
        .gpio_e(gpio_e),
        .gpio_i(gpio_i),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer; returns #1 after the edge so the response is visible.
    task automatic xfer(input logic wen, input logic [5:0] adr,
                        input logic [3:0] ben, input logic [31:0] wdt);
        bus_vld = 1'b1;
        bus_wen = wen;
        bus_adr = adr;
        bus_ben = ben;
        bus_wdt = wdt;
        @(posedge clk);
        #1;
        bus_vld = 1'b0;
        bus_wen = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] adr,
                          input logic [31:0] exp);
        xfer(1'b0, adr, 4'hF, 32'h0);
        chk(tag, bus_rdt, exp);
        chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    task automatic wr(input logic [5:0] adr, input logic [3:0] ben,
                      input logic [31:0] wdt);
        xfer(1'b1, adr, ben, wdt);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        bus_vld = 1'b0;
        bus_wen = 1'b0;
        bus_adr = '0;
        bus_ben = '0;
        bus_wdt = '0;
        gpio_i  = '0;
        #2;
        chk("rst_gpio_o", gpio_o, 32'h0);
        chk("rst_gpio_e", gpio_e, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdy", {31'd0, bus_rdy}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        rd_chk("rd_out0", 6'h00, 32'h0);
        rd_chk("rd_oe0", 6'h04, 32'h0);
        rd_chk("rd_rise0", 6'h18, 32'h0);
        rd_chk("rd_sts0", 6'h20, 32'h0);
        chk("irq0", {31'd0, irq}, 32'd0);

        wr(6'h00, 4'hF, 32'h0000_00F0);
        chk("out_wr", gpio_o, 32'h0000_00F0);
        wr(6'h0C, 4'hF, 32'h0000_000F);
        chk("out_set", gpio_o, 32'h0000_00FF);
        wr(6'h10, 4'hF, 32'h0000_0030);
        chk("out_clr", gpio_o, 32'h0000_00CF);
        wr(6'h14, 4'hF, 32'h8000_0001);
        chk("out_tgl", gpio_o, 32'h8000_00CE);
        rd_chk("rd_out1", 6'h00, 32'h8000_00CE);
        rd_chk("rd_set", 6'h0C, 32'h0);

        wr(6'h04, 4'b0101, 32'hFFFF_FFFF);
        chk("oe_ben", gpio_e, 32'h00FF_00FF);
        rd_chk("rd_oe1", 6'h04, 32'h00FF_00FF);
        wr(6'h0C, 4'b0010, 32'hFFFF_FFFF);
        chk("set_ben", gpio_o, 32'h8000_FFCE);
        wr(6'h10, 4'b1000, 32'hFFFF_FFFF);
        chk("clr_ben", gpio_o, 32'h0000_FFCE);

        wr(6'h18, 4'hF, 32'h1);
        gpio_i = 32'h1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk($sformatf("irq_lat%0d", k), {31'd0, irq},
                (k == 2) ? 32'd1 : 32'd0);
        end
        rd_chk("rd_sts1", 6'h20, 32'h1);
        rd_chk("rd_in1", 6'h08, 32'h1);
        wr(6'h20, 4'hF, 32'h1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        rd_chk("rd_sts2", 6'h20, 32'h0);
        gpio_i = 32'h0;
        tick(5);
        chk("irq_nofall", {31'd0, irq}, 32'd0);
        rd_chk("rd_sts3", 6'h20, 32'h0);

        wr(6'h18, 4'hF, 32'h5);
        gpio_i = 32'h5;
        tick(4);
        rd_chk("rd_sts_multi", 6'h20, 32'h5);
        chk("irq_multi", {31'd0, irq}, 32'd1);
        wr(6'h20, 4'b0000, 32'h5);
        rd_chk("rd_sts_ben0", 6'h20, 32'h5);
        wr(6'h20, 4'b0001, 32'h4);
        rd_chk("rd_sts_w1c4", 6'h20, 32'h1);
        gpio_i = 32'h0;
        tick(4);
        rd_chk("rd_sts_keep", 6'h20, 32'h1);

        gpio_i = 32'h1;
        tick(2);
        wr(6'h20, 4'hF, 32'h1);
        chk("irq_race", {31'd0, irq}, 32'd1);
        rd_chk("rd_sts_race", 6'h20, 32'h1);

        wr(6'h18, 4'hF, 32'h0);
        rd_chk("rd_sts_endis", 6'h20, 32'h1);
        chk("irq_endis", {31'd0, irq}, 32'd1);
        wr(6'h20, 4'hF, 32'h1);
        chk("irq_clr2", {31'd0, irq}, 32'd0);

        gpio_i = 32'h9;
        tick(4);
        wr(6'h18, 4'hF, 32'h8);
        tick(2);
        rd_chk("rd_sts_late", 6'h20, 32'h0);
        chk("irq_late", {31'd0, irq}, 32'd0);

        wr(6'h1C, 4'hF, 32'h8);
        gpio_i = 32'h1;
        tick(4);
        rd_chk("rd_sts_fall", 6'h20, 32'h8);
        chk("irq_fall", {31'd0, irq}, 32'd1);
        rd_chk("rd_fall", 6'h1C, 32'h8);
        wr(6'h20, 4'hF, 32'h8);
        wr(6'h1C, 4'hF, 32'h0);
        chk("irq_fall_clr", {31'd0, irq}, 32'd0);

        rd_chk("rd_out2", 6'h00, 32'h0000_FFCE);
        xfer(1'b0, 6'h24, 4'hF, 32'h0);
        chk("err_rd24", {31'd0, bus_err}, 32'd1);
        chk("err_rd24_rdt", bus_rdt, 32'h0);
        rd_chk("rd_out3", 6'h00, 32'h0000_FFCE);
        xfer(1'b0, 6'h02, 4'hF, 32'h0);
        chk("err_rd02", {31'd0, bus_err}, 32'd1);
        chk("err_rd02_rdt", bus_rdt, 32'h0);
        xfer(1'b1, 6'h08, 4'hF, 32'hFFFF_FFFF);
        chk("err_wr08", {31'd0, bus_err}, 32'd1);
        chk("err_wr08_rdt", bus_rdt, 32'h0);
        xfer(1'b1, 6'h01, 4'hF, 32'hFFFF_FFFF);
        chk("err_wr01", {31'd0, bus_err}, 32'd1);
        chk("err_wr01_out", gpio_o, 32'h0000_FFCE);
        xfer(1'b1, 6'h3C, 4'hF, 32'hFFFF_FFFF);
        chk("err_wr3c", {31'd0, bus_err}, 32'd1);
        chk("err_wr3c_oe", gpio_e, 32'h00FF_00FF);
        rd_chk("rd_oe2", 6'h04, 32'h00FF_00FF);
        wr(6'h04, 4'hF, 32'h00FF_00FF);
        chk("rdt_hold", bus_rdt, 32'h00FF_00FF);
        chk("wr_noerr", {31'd0, bus_err}, 32'd0);

        wr(6'h18, 4'hF, 32'h10);
        gpio_i = 32'h11;
        tick(4);
        chk("irq_pre_rst", {31'd0, irq}, 32'd1);
        bus_vld = 1'b1;
        bus_wen = 1'b1;
        bus_adr = 6'h00;
        bus_ben = 4'hF;
        bus_wdt = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o", gpio_o, 32'h0);
        chk("mid_rst_e", gpio_e, 32'h0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_rdt", bus_rdt, 32'h0);
        chk("mid_rst_err", {31'd0, bus_err}, 32'd0);
        bus_vld = 1'b0;
        bus_wen = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        rd_chk("rd_out_rst", 6'h00, 32'h0);
        rd_chk("rd_rise_rst", 6'h18, 32'h0);
        tick(4);
        rd_chk("rd_sts_rst", 6'h20, 32'h0);
        chk("irq_post_rst", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
